// File: rtl/vector_gates_pkg.sv
// Shared constants and helpers for the vector_gates unit and its bench model.
package vector_gates_pkg;

    localparam int VG_DEFAULT_WIDTH = 3;

    // Inverted-operand concatenation at the default width: b in the upper half.
    function automatic logic [2*VG_DEFAULT_WIDTH-1:0] vg_not_concat(
        input logic [VG_DEFAULT_WIDTH-1:0] a,
        input logic [VG_DEFAULT_WIDTH-1:0] b
    );
        return {~b, ~a};
    endfunction

endpackage

// File: rtl/vector_gates_core.sv
// Combinational core: bitwise OR, logical OR and inverted concatenation of two operands.
module vector_gates_core #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0]   in_1,
    input  logic [WIDTH-1:0]   in_2,
    output logic [WIDTH-1:0]   bitw,
    output logic               any_set,
    output logic [2*WIDTH-1:0] not_cat
);

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            assign bitw[i]          = in_1[i] | in_2[i];
            assign not_cat[i]       = ~in_1[i];
            assign not_cat[WIDTH+i] = ~in_2[i];
        end
    endgenerate

    assign any_set = |bitw;

endmodule

// File: rtl/vector_gates.sv
// Registered vector-logic unit: one-cycle latency, one result per cycle, no backpressure.
module vector_gates
    import vector_gates_pkg::*;
#(
    parameter int WIDTH = VG_DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_1,
    input  logic [WIDTH-1:0]   in_2,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_bitw,
    output logic               out_logic,
    output logic [2*WIDTH-1:0] out_not
);

    logic [WIDTH-1:0]   bitw;
    logic               any_set;
    logic [2*WIDTH-1:0] not_cat;

    vector_gates_core #(.WIDTH(WIDTH)) u_core (
        .in_1    (in_1),
        .in_2    (in_2),
        .bitw    (bitw),
        .any_set (any_set),
        .not_cat (not_cat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_bitw  <= '0;
            out_logic <= 1'b0;
            out_not   <= '0;
        end else begin
            out_valid <= in_valid;
            // Data registers only load on capture so idle slots keep the last result.
            if (in_valid) begin
                out_bitw  <= bitw;
                out_logic <= any_set;
                out_not   <= not_cat;
            end
        end
    end

endmodule

// File: tb/tb_vector_gates.sv
// Directed table-driven bench for vector_gates plus async-reset corner sequences.
module tb_vector_gates;
    import vector_gates_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [2:0] in_1;
    logic [2:0] in_2;
    logic       out_valid;
    logic [2:0] out_bitw;
    logic       out_logic;
    logic [5:0] out_not;

    int n_total = 0;
    int n_pass  = 0;

    vector_gates dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_1      (in_1),
        .in_2      (in_2),
        .out_valid (out_valid),
        .out_bitw  (out_bitw),
        .out_logic (out_logic),
        .out_not   (out_not)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic [2:0] a;
        logic [2:0] b;
        logic       e_valid;
        logic [2:0] e_bitw;
        logic       e_logic;
        logic [5:0] e_not;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [2:0] bw,
                           input logic lg, input logic [5:0] nt);
        chk({tag, ".valid"}, 64'(out_valid), 64'(v));
        chk({tag, ".bitw"},  64'(out_bitw),  64'(bw));
        chk({tag, ".logic"}, 64'(out_logic), 64'(lg));
        chk({tag, ".not"},   64'(out_not),   64'(nt));
    endtask

    initial begin
        // zero operands
        vecs[0]  = '{1'b1, 3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 6'b111111};
        // sweep A with B = 111, with a two-slot valid gap after A = 3
        vecs[1]  = '{1'b1, 3'b000, 3'b111, 1'b1, 3'b111, 1'b1, 6'b000111};
        vecs[2]  = '{1'b1, 3'b001, 3'b111, 1'b1, 3'b111, 1'b1, 6'b000110};
        vecs[3]  = '{1'b1, 3'b010, 3'b111, 1'b1, 3'b111, 1'b1, 6'b000101};
        vecs[4]  = '{1'b1, 3'b011, 3'b111, 1'b1, 3'b111, 1'b1, 6'b000100};
        vecs[5]  = '{1'b0, 3'b110, 3'b001, 1'b0, 3'b111, 1'b1, 6'b000100};
        vecs[6]  = '{1'b0, 3'b000, 3'b000, 1'b0, 3'b111, 1'b1, 6'b000100};
        vecs[7]  = '{1'b1, 3'b100, 3'b111, 1'b1, 3'b111, 1'b1, 6'b000011};
        vecs[8]  = '{1'b1, 3'b101, 3'b111, 1'b1, 3'b111, 1'b1, 6'b000010};
        vecs[9]  = '{1'b1, 3'b110, 3'b111, 1'b1, 3'b111, 1'b1, 6'b000001};
        vecs[10] = '{1'b1, 3'b111, 3'b111, 1'b1, 3'b111, 1'b1, 6'b000000};
        // single-bit operand, mixed, A all-ones with B zero
        vecs[11] = '{1'b1, 3'b001, 3'b000, 1'b1, 3'b001, 1'b1, 6'b111110};
        vecs[12] = '{1'b1, 3'b100, 3'b010, 1'b1, 3'b110, 1'b1, 6'b101011};
        vecs[13] = '{1'b1, 3'b111, 3'b000, 1'b1, 3'b111, 1'b1, 6'b111000};
        vecs[14] = '{1'b1, 3'b010, 3'b000, 1'b1, 3'b010, 1'b1, 6'b111101};
        vecs[15] = '{1'b1, 3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 6'b111111};

        rst_n = 1'b0; in_valid = 1'b1; in_1 = 3'b111; in_2 = 3'b111;
        #1;
        chk_all("reset_initial", 1'b0, 3'b000, 1'b0, 6'b000000);
        @(posedge clk); #2;
        chk_all("reset_held", 1'b0, 3'b000, 1'b0, 6'b000000);

        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        @(posedge clk); #2;
        chk("release_no_capture.valid", 64'(out_valid), 64'd0);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            in_valid = vecs[i].vld; in_1 = vecs[i].a; in_2 = vecs[i].b;
            @(posedge clk); #2;
            chk_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_bitw,
                    vecs[i].e_logic, vecs[i].e_not);
        end

        // Package helper agrees with a hand-computed value.
        chk("pkg_not_concat", 64'(vg_not_concat(3'b100, 3'b010)), 64'(6'b101011));

        // Mid-stream reset: outputs clear at once and the pending capture is dropped.
        @(negedge clk);
        in_valid = 1'b1; in_1 = 3'b101; in_2 = 3'b000;
        #2 rst_n = 1'b0;
        #1;
        chk_all("reset_async", 1'b0, 3'b000, 1'b0, 6'b000000);
        @(posedge clk); #2;
        chk_all("reset_drop_pending", 1'b0, 3'b000, 1'b0, 6'b000000);

        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        @(posedge clk); #2;
        chk("post_reset_idle.valid", 64'(out_valid), 64'd0);

        @(negedge clk);
        in_valid = 1'b1; in_1 = 3'b101; in_2 = 3'b000;
        @(posedge clk); #2;
        chk_all("post_reset_first", 1'b1, 3'b101, 1'b1, 6'b111010);

        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #2;
        chk_all("final_idle_hold", 1'b0, 3'b101, 1'b1, 6'b111010);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vector_gates.md
Name: vector_gates

Overview:
- Registered vector-logic unit that computes three results from two equal-width operand vectors:
  - bitwise OR;
  - logical OR, i.e. whether either operand is non-zero;
  - the concatenated bitwise inversion of both operands.
- Used as a small datapath leaf wherever combined operand flags and inverted operand fields are needed.
- Outputs are registered; latency is one cycle.

Parameters:
- WIDTH, default 3, bit width of each operand vector (WIDTH >= 1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assertion, active-low.
- in_valid  input  1  in_1/in_2 qualify for capture this cycle.
- in_1  input  WIDTH  operand A.
- in_2  input  WIDTH  operand B.
- out_valid  output  1  outputs hold the result of a captured operand pair.
- out_bitw  output  WIDTH  bitwise OR: in_1 | in_2.
- out_logic  output  1  logical OR: 1 if in_1 != 0 or in_2 != 0.
- out_not  output  2*WIDTH  {~in_2, ~in_1}; in_2 inverted in the upper half, in_1 inverted in the lower half.

Behaviour:
- Reset (rst_n = 0) takes effect immediately, without waiting for clk:
  - out_valid = 0, out_bitw = 0, out_logic = 0, out_not = 0.
  - Outputs hold these values while rst_n is low.
- Capture: on a rising clk edge with rst_n = 1 and in_valid = 1, the unit registers:
  - out_bitw <= in_1 | in_2
  - out_logic <= (|in_1) | (|in_2)
  - out_not[WIDTH-1:0] <= ~in_1
  - out_not[2*WIDTH-1:WIDTH] <= ~in_2
  - out_valid <= 1
- Latency:
  - Exactly 1 cycle from operand capture to result.
  - Throughput is 1 result per cycle.
  - No backpressure: there is no ready signal, and the consumer must accept every result.
- Idle: on a rising edge with in_valid = 0:
  - out_valid <= 0.
  - Data outputs hold their last values; they are don't-care while out_valid = 0.
- Widths:
  - No carries or extension.
  - out_not is exactly 2*WIDTH bits.
  - out_logic is a single reduction bit.
- Boundaries:
  - Both operands all-zero: out_bitw = 0, out_logic = 0, out_not all ones.
  - Either operand all-ones: out_bitw all ones, out_logic = 1.
- Reset mid-stream: an asserted rst_n discards any pending result. The first valid result after release follows the first capture edge.
- Reset release: removal of rst_n must be synchronised externally to clk. The unit performs no capture on the release edge unless rst_n is already high at that edge.
- The unit has no internal state other than the output registers.

Decomposition:
- Shared package vector_gates_pkg holds:
  - the constant VG_DEFAULT_WIDTH = 3;
  - helper function vg_not_concat(a, b), returning {~b, ~a}, for reuse by the bench model.
- One combinational sub-module, vector_gates_core, computes bitw/logic/not from in_1/in_2. The top level adds only the valid and output registers.

Test Plan:
- Reset: assert rst_n = 0 asynchronously mid-cycle -> all outputs 0 immediately, and out_valid = 0 after release until the first capture.
- Zero operands: in_1 = 3'b000, in_2 = 3'b000, in_valid = 1 -> next cycle out_bitw = 3'b000, out_logic = 0, out_not = 6'b111111, out_valid = 1.
- Sweep A with B fixed: in_2 = 3'b111, in_1 stepping 0..7 one per cycle -> each result one cycle later, with out_bitw = 3'b111, out_logic = 1, out_not = {3'b000, ~in_1} (e.g. in_1 = 3'b101 -> out_not = 6'b000010).
- Single-bit operand: in_1 = 3'b001, in_2 = 3'b000 -> out_bitw = 3'b001, out_logic = 1, out_not = 6'b111110.
- Mixed: in_1 = 3'b100, in_2 = 3'b010 -> out_bitw = 3'b110, out_logic = 1, out_not = 6'b101011.
- Valid gating: drop in_valid for 2 cycles mid-sweep -> out_valid low for exactly those 2 result slots, and data outputs unchanged.
